// File: rtl/qam16_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : qam16_modulator
//  Description : 16QAM transmitter. A serial bit stream is assembled into
//                4-bit symbols, double-buffered, Gray-mapped to I/Q levels,
//                held for SPS samples and mixed onto an fs/4 carrier.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam16_modulator #(
  parameter int SPS = 8,   // samples per symbol (4..64)
  parameter int AMP = 32   // unit amplitude; 3*AMP must fit in 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic signed [7:0] di,
  output logic signed [7:0] dq,
  output logic signed [7:0] dout,
  output logic              sym_strobe,
  output logic              underrun
);

  localparam int                SC_W  = $clog2(SPS);
  localparam logic [SC_W-1:0]   c_SC_LAST = SC_W'(SPS - 1);
  localparam logic signed [7:0] c_L1  = 8'(AMP);
  localparam logic signed [7:0] c_L3  = 8'(3 * AMP);

  logic [3:0]             r_asm_reg;
  logic [2:0]             r_asm_cnt;
  logic [3:0]             r_hold;
  logic                   r_hold_full;
  logic [SC_W-1:0]        r_sc;
  logic [1:0]             r_ph;
  logic signed [7:0]      r_di;
  logic signed [7:0]      r_dq;
  logic signed [7:0]      r_dout;
  logic                   r_sym_strobe;
  logic                   r_underrun;

  logic                   w_boundary;
  logic                   w_consume;
  logic                   w_transfer;
  logic                   w_accept;

  // Gray mapping of a 2-bit field onto one of four amplitude levels.
  function automatic logic signed [7:0] f_map(input logic [1:0] b);
    logic signed [7:0] v;
    case (b)
      2'b00:   v = -c_L3;
      2'b01:   v = -c_L1;
      2'b11:   v =  c_L1;
      default: v =  c_L3;
    endcase
    return v;
  endfunction

  // Handshake, symbol boundary and buffer-movement decisions.
  always_comb begin
    bit_ready  = (r_asm_cnt < 3'd4);
    w_accept   = bit_valid && bit_ready;
    w_boundary = en && (r_sc == c_SC_LAST);
    w_consume  = w_boundary && r_hold_full;
    // The hold slot may be refilled in the very cycle it is consumed.
    w_transfer = (r_asm_cnt == 3'd4) && (!r_hold_full || w_consume);
  end

  // Serial-to-parallel assembler: MSB arrives first, shifts toward bit 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm_reg <= 4'd0;
      r_asm_cnt <= 3'd0;
    end else if (w_transfer) begin
      r_asm_cnt <= 3'd0;
    end else if (w_accept) begin
      r_asm_reg <= {r_asm_reg[2:0], bit_in};
      r_asm_cnt <= r_asm_cnt + 3'd1;
    end
  end

  // Hold buffer: second stage of the double buffer, drained at boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= 4'd0;
      r_hold_full <= 1'b0;
    end else if (w_transfer) begin
      r_hold      <= r_asm_reg;
      r_hold_full <= 1'b1;
    end else if (w_consume) begin
      r_hold_full <= 1'b0;
    end
  end

  // Symbol timer and carrier phase; both parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_sc <= '0;
      r_ph <= 2'd0;
    end else begin
      r_sc <= (r_sc == c_SC_LAST) ? '0 : r_sc + 1'b1;
      r_ph <= r_ph + 2'd1;
    end
  end

  // Symbol levels: load the buffered symbol, or zeros on an empty boundary.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_di         <= 8'sd0;
      r_dq         <= 8'sd0;
      r_sym_strobe <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_sym_strobe <= w_consume;
      r_underrun   <= w_boundary && !r_hold_full;
      if (w_boundary) begin
        r_di <= r_hold_full ? f_map(r_hold[3:2]) : 8'sd0;
        r_dq <= r_hold_full ? f_map(r_hold[1:0]) : 8'sd0;
      end
    end
  end

  // fs/4 mixer: cos/sin reduce to the sequence (1,0),(0,1),(-1,0),(0,-1).
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_dout <= 8'sd0;
    end else begin
      case (r_ph)
        2'd0:    r_dout <= r_di;
        2'd1:    r_dout <= -r_dq;
        2'd2:    r_dout <= -r_di;
        default: r_dout <= r_dq;
      endcase
    end
  end

  assign di         = r_di;
  assign dq         = r_dq;
  assign dout       = r_dout;
  assign sym_strobe = r_sym_strobe;
  assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: doc/qam16_modulator.md
Name: qam16_modulator

Overview:
- 16QAM transmitter that produces the 8-bit signed passband sample stream the carrier-recovery demodulator consumes.
- Accepts a serial bit stream with a valid/ready handshake and assembles 4-bit symbols through a double buffer.
- Gray-maps each symbol to I/Q levels, holds them for SPS samples (rectangular shaping), and mixes onto an fs/4 carrier (2 MHz at the 8 MHz system clock).

Parameters:
- SPS, 8, samples per symbol; integer, 4..64.
- AMP, 32, unit amplitude; levels are ±AMP and ±3*AMP; 3*AMP must be ≤127.

Ports:
- clk  in  1  system/sample clock, 8 MHz.
- rst  in  1  synchronous reset, active-high.
- en  in  1  modulator run enable.
- bit_in  in  1  serial data bit; first bit of a symbol is its MSB.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  block accepts bit_in this cycle.
- di  out  8 signed  current I symbol level.
- dq  out  8 signed  current Q symbol level.
- dout  out  8 signed  passband sample.
- sym_strobe  out  1  one-cycle pulse when a new symbol loads into di/dq.
- underrun  out  1  one-cycle pulse when a symbol boundary finds no symbol buffered.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: di=dq=dout=0; sym_strobe=underrun=0; asm_cnt=0; hold_full=0; sc=0; ph=0. bit_ready is 1 in the first cycle after reset.
- Assembler:
  - asm_reg is a 4-bit shift register, left shift, new bit into the LSB. asm_cnt runs 0..4.
  - bit_ready = (asm_cnt<4).
  - A bit is accepted when bit_valid && bit_ready; asm_cnt then increments.
- Hold buffer: a 4-bit register with a hold_full flag.
  - Transfer occurs when asm_cnt==4 and (hold_full==0 or hold is consumed this same cycle).
  - On transfer: hold <= asm_reg, hold_full <= 1, asm_cnt <= 0.
  - bit_ready is 0 during the transfer cycle.
- Symbol timer: sc counts 0..SPS-1 and wraps while en=1. The boundary is the cycle with sc==SPS-1 && en.
  - At a boundary with hold_full: di/dq <= map(hold), hold_full <= 0 (unless refilled the same cycle), sym_strobe=1 next cycle.
  - At a boundary without hold_full: di=dq <= 0, underrun=1 next cycle, sym_strobe=0.
- Mapping (Gray): I from bits[3:2], Q from bits[1:0].
  - 00 -> -3*AMP, 01 -> -AMP, 11 -> +AMP, 10 -> +3*AMP.
- Carrier phase: ph is a 2-bit counter that increments every cycle while en=1.
  - dout is registered: dout <= (ph==0: di, 1: -dq, 2: -di, 3: dq), using pre-edge di/dq/ph.
  - dout therefore lags di/dq by one cycle.
- Arithmetic: negation in 8 bits. No overflow is possible because |level| ≤ 3*AMP ≤ 127.
- en=0: sc, ph, di, dq and dout are held at 0; sym_strobe=underrun=0.
  - The assembler and hold buffer keep operating (pre-loading is allowed).
  - On en rising, the first boundary occurs SPS cycles later.
- Reset mid-operation: all state returns to reset values on the next edge. Partially assembled bits and the buffered symbol are discarded.
- Sustained throughput: 4 bits per SPS cycles. The input may stall arbitrarily, and stalls produce underrun symbols (zeros).

Test Plan:
1. Reset then en=1, bits 1,0,1,1 (hold=1011) streamed early:
   - at the first boundary, di=+3*AMP=96 and dq=+32, with sym_strobe pulsed;
   - dout sequence is 96,-32,-96,32 repeating.
2. Stream all 16 symbols 0000..1111 back-to-back with bit_valid=1:
   - di/dq match the Gray table for each symbol;
   - no underrun;
   - bit_ready deasserts only on transfer cycles and while both buffers are full.
3. No bits supplied, en=1:
   - underrun pulses every SPS=8 cycles;
   - di=dq=dout=0.
4. Hold full and asm_cnt==4 at a boundary (simultaneous consume and transfer):
   - the hold symbol loads into di/dq;
   - the assembled symbol moves to hold in the same cycle;
   - the next boundary outputs it with no underrun.
5. Assert rst mid-symbol after 2 bits accepted:
   - all outputs are 0 the next cycle;
   - the following 4 bits form a fresh symbol, with no leftover bits.
6. en=0 while bits 0,0,0,0 are fed:
   - dout stays 0 and hold_full=1;
   - after raising en, di=dq=-96 at the first boundary (cycle 8).
